edge_burst_gen: RTL

Programmable pulse-burst transmitter. On a `start` request it emits `num_edges` rising edges on `signal` with a programmable high and low time per pulse, then reports completion. It is the stimulus/driver side of the rising-edge window detector. It sits upstream of the detector, drives its `signal` input directly, and produces bursts that are known to meet or violate the detector's edge-count and window rules.

---
 rtl/edge_burst_gen_if.sv | 45 ++++
 rtl/edge_burst_gen.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/edge_burst_gen_if.sv
// ---------------------------------------------------------------------------
// edge_burst_gen_if
// Bundle of request/configuration and waveform/status signals between a
// burst requester (master) and the edge_burst_gen block (slave).
//
// Handshake: the master raises start with num_edges/high_cycles/low_cycles
// valid in the same cycle. The slave takes the request on a rising clk edge
// only while busy=0, so busy acts as the inverse of ready. A start seen while
// busy=1 is dropped, not queued. done pulses for one cycle on normal
// completion. abort cancels a running burst and does nothing while idle.
//
// Signals:
//   start        master->slave  burst request
//   num_edges    master->slave  rising edges per burst (0 legal)
//   high_cycles  master->slave  high time per pulse (0 acts as 1)
//   low_cycles   master->slave  low time after each pulse (0 acts as 1)
//   abort        master->slave  cancel an active burst
//   signal       slave->master  generated waveform (registered)
//   busy         slave->master  burst in progress
//   done         slave->master  one-cycle completion pulse
//   edges_sent   slave->master  rising edges emitted in current/last burst
// ---------------------------------------------------------------------------
interface edge_burst_gen_if #(
  parameter int CW = 3
);
  logic          start;
  logic [CW-1:0] num_edges;
  logic [CW-1:0] high_cycles;
  logic [CW-1:0] low_cycles;
  logic          abort;
  logic          signal;
  logic          busy;
  logic          done;
  logic [CW-1:0] edges_sent;

  modport master (
    output start, num_edges, high_cycles, low_cycles, abort,
    input  signal, busy, done, edges_sent
  );

  modport slave (
    input  start, num_edges, high_cycles, low_cycles, abort,
    output signal, busy, done, edges_sent
  );
endinterface

// File: rtl/edge_burst_gen.sv
// ---------------------------------------------------------------------------
// edge_burst_gen
// Programmable pulse-burst transmitter. On an accepted start it drives
// num_edges pulses on signal, each high for max(high_cycles,1) cycles and
// then low for max(low_cycles,1) cycles, and pulses done when the last low
// phase ends. Burst parameters are captured when start is accepted.
//
// Ports:
//   clk          in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   bus          slave modport of edge_burst_gen_if (see interface header)
//   dbg_state_o  out  current FSM state (0=IDLE, 1=HIGH, 2=LOW)
// ---------------------------------------------------------------------------
module edge_burst_gen #(
  parameter int CW = 3
) (
  input  logic                clk,
  input  logic                reset,
  edge_burst_gen_if.slave     bus,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q,  state_d;
  logic          signal_q, signal_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;
  logic [CW-1:0] edges_q,  edges_d;
  // Counts cycles already spent in the current phase, starting at 1. The
  // end-of-phase test happens before any increment, so with a CW-bit counter
  // a phase length of 2^CW-1 never overflows.
  logic [CW-1:0] phase_q,  phase_d;
  logic [CW-1:0] n_q,      n_d;
  // Phase lengths are stored already clamped to at least 1.
  logic [CW-1:0] h_q,      h_d;
  logic [CW-1:0] l_q,      l_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      edges_q  <= '0;
      phase_q  <= '0;
      n_q      <= '0;
      h_q      <= '0;
      l_q      <= '0;
    end else begin
      state_q  <= state_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      edges_q  <= edges_d;
      phase_q  <= phase_d;
      n_q      <= n_d;
      h_q      <= h_d;
      l_q      <= l_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    edges_d  = edges_q;
    phase_d  = phase_q;
    n_d      = n_q;
    h_d      = h_q;
    l_d      = l_q;

    case (state_q)
      IDLE: begin
        // abort is meaningless here, so start always takes priority.
        if (bus.start) begin
          n_d = bus.num_edges;
          h_d = (bus.high_cycles == '0) ? ONE : bus.high_cycles;
          l_d = (bus.low_cycles  == '0) ? ONE : bus.low_cycles;
          if (bus.num_edges != '0) begin
            state_d  = HIGH;
            signal_d = 1'b1;
            busy_d   = 1'b1;
            edges_d  = ONE;
            phase_d  = ONE;
          end else begin
            // Empty burst completes immediately without leaving IDLE.
            done_d  = 1'b1;
            edges_d = '0;
          end
        end
      end

      HIGH: begin
        if (bus.abort) begin
          state_d  = IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          phase_d  = '0;
        end else if (phase_q >= h_q) begin
          state_d  = LOW;
          signal_d = 1'b0;
          phase_d  = ONE;
        end else begin
          phase_d = phase_q + ONE;
        end
      end

      LOW: begin
        if (bus.abort) begin
          state_d  = IDLE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          phase_d  = '0;
        end else if (phase_q >= l_q) begin
          if (edges_q < n_q) begin
            state_d  = HIGH;
            signal_d = 1'b1;
            edges_d  = edges_q + ONE;
            phase_d  = ONE;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q + ONE;
        end
      end

      default: begin
        state_d  = IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
        phase_d  = '0;
      end
    endcase
  end

  assign bus.signal     = signal_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.edges_sent = edges_q;
  assign dbg_state_o    = state_q;

endmodule
